// File: rtl/feature_gather_pkg.sv
// Shared constants and types for the feature gather stage that feeds the
// arrhythmia decision-tree classifier.
package feature_gather_pkg;

  localparam int NUM_FEATURES_DEF = 279;
  localparam int FEAT_W           = 8;
  localparam int NUM_SEL          = 5;

  // Record indices consumed by the tree, in out_f0..out_f4 order
  localparam int FEAT_IDX [NUM_SEL] = '{13, 27, 235, 264, 278};

  typedef struct packed {
    logic [FEAT_W-1:0] f4;
    logic [FEAT_W-1:0] f3;
    logic [FEAT_W-1:0] f2;
    logic [FEAT_W-1:0] f1;
    logic [FEAT_W-1:0] f0;
  } feat_vec_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_gather_record_beat_counter.sv
// Beat index within a record plus record-framing classification of the
// accepted beat (final / good / framing error).
module record_beat_counter
  import feature_gather_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int CW           = cnt_width(NUM_FEATURES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          in_last,
  output logic [CW-1:0] cnt,
  output logic          final_beat,
  output logic          good_rec,
  output logic          frame_err
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FEATURES - 1);

  logic [CW-1:0] cnt_r;
  logic          at_last_s;

  assign cnt       = cnt_r;
  assign at_last_s = (cnt_r == LAST_IDX);

  // A record ends on whichever comes first: in_last or the last index
  always_comb begin
    final_beat = accept && (at_last_s || in_last);
    good_rec   = accept && at_last_s && in_last;
    frame_err  = accept && (at_last_s != in_last);
  end

  // Beat index: wraps to zero on every final beat, holds across gaps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (final_beat) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/feature_gather.sv
// Gathers the five tree features out of a patient-record byte stream and
// presents them as one registered vector with a valid/ready handshake.
module feature_gather
  import feature_gather_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int W            = FEAT_W,
  parameter int IDX0         = FEAT_IDX[0],
  parameter int IDX1         = FEAT_IDX[1],
  parameter int IDX2         = FEAT_IDX[2],
  parameter int IDX3         = FEAT_IDX[3],
  parameter int IDX4         = FEAT_IDX[4]
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_f0,
  output logic [W-1:0] out_f1,
  output logic [W-1:0] out_f2,
  output logic [W-1:0] out_f3,
  output logic [W-1:0] out_f4,
  output logic         rec_err
);

  localparam int CW = cnt_width(NUM_FEATURES);
  localparam int IDX_A [NUM_SEL] = '{IDX0, IDX1, IDX2, IDX3, IDX4};

  logic [CW-1:0]      cnt_s;
  logic               accept_s;
  logic               final_beat_s;
  logic               good_rec_s;
  logic               frame_err_s;
  logic               out_free_s;
  logic               load_s;
  logic               pending_next_s;
  logic               valid_next_s;
  logic [NUM_SEL-1:0] hit_s;
  logic [W-1:0]       cap_next_s [NUM_SEL];

  logic               pending_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               rec_err_r;
  logic [W-1:0]       cap_r      [NUM_SEL];
  logic [W-1:0]       out_f_r    [NUM_SEL];

  assign accept_s   = in_valid && in_ready_r;
  assign out_free_s = !out_valid_r || out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign rec_err   = rec_err_r;
  assign out_f0    = out_f_r[0];
  assign out_f1    = out_f_r[1];
  assign out_f2    = out_f_r[2];
  assign out_f3    = out_f_r[3];
  assign out_f4    = out_f_r[4];

  record_beat_counter #(
    .NUM_FEATURES (NUM_FEATURES),
    .CW           (CW)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept_s),
    .in_last    (in_last),
    .cnt        (cnt_s),
    .final_beat (final_beat_s),
    .good_rec   (good_rec_s),
    .frame_err  (frame_err_s)
  );

  // Bypass the byte being accepted so a feature at the final index can
  // reach the output on the same edge it is captured
  always_comb begin
    for (int k = 0; k < NUM_SEL; k++) begin
      hit_s[k] = accept_s && (cnt_s == CW'(IDX_A[k]));
      if (hit_s[k]) begin
        cap_next_s[k] = in_data;
      end else begin
        cap_next_s[k] = cap_r[k];
      end
    end
  end

  // Transfer decision: load now, park the record as pending, or release it
  always_comb begin
    load_s         = 1'b0;
    pending_next_s = pending_r;
    if (pending_r) begin
      if (out_ready) begin
        load_s         = 1'b1;
        pending_next_s = 1'b0;
      end else begin
        pending_next_s = 1'b1;
      end
    end else if (good_rec_s) begin
      if (out_free_s) begin
        load_s = 1'b1;
      end else begin
        pending_next_s = 1'b1;
      end
    end else begin
      pending_next_s = 1'b0;
    end

    if (load_s) begin
      valid_next_s = 1'b1;
    end else if (out_ready) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = out_valid_r;
    end
  end

  // Capture, output and handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      rec_err_r   <= 1'b0;
      for (int k = 0; k < NUM_SEL; k++) begin
        cap_r[k]   <= {W{1'b0}};
        out_f_r[k] <= {W{1'b0}};
      end
    end else begin
      pending_r   <= pending_next_s;
      in_ready_r  <= !pending_next_s;
      out_valid_r <= valid_next_s;
      rec_err_r   <= final_beat_s && frame_err_s;
      for (int k = 0; k < NUM_SEL; k++) begin
        cap_r[k] <= cap_next_s[k];
        if (load_s) begin
          out_f_r[k] <= cap_next_s[k];
        end else begin
          out_f_r[k] <= out_f_r[k];
        end
      end
    end
  end

endmodule
